// File: rtl/sramgen_pkg.sv
// Shared definitions for the parameterised SRAM macro model.
//   sram_state_e  : sweep controller states (CLEAR zeroes the array, READY serves accesses)
//   RL_* / WT_*   : legal ranges for READ_LATENCY and WRITE_THROUGH
//   rl_legal/wt_legal : elaboration-time legality helpers
package sramgen_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int unsigned RL_MIN = 1;
  localparam int unsigned RL_MAX = 2;
  localparam int unsigned WT_MIN = 0;
  localparam int unsigned WT_MAX = 1;

  function automatic bit rl_legal(input int unsigned rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

  function automatic bit wt_legal(input int unsigned wt);
    return (wt >= WT_MIN) && (wt <= WT_MAX);
  endfunction

endpackage

// File: rtl/sramgen_clear_fsm.sv
// Array-zeroing sweep controller.
//   clk      : rising-edge clock
//   rstb     : asynchronous active-low reset (restarts the sweep from address 0)
//   clr      : request a new sweep (honoured only in READY)
//   ready    : array accepts accesses
//   clr_we   : sweep write strobe (zero data)
//   clr_addr : sweep write address
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | writing zero to clr_addr each cycle, counting up from 0
// ST_READY | sweep done, array open for accesses; clr_addr parked at 0
module sramgen_clear_fsm
  import sramgen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  clr,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  sram_state_e           r_state;
  sram_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Leaving CLEAR happens on the edge that writes the last address, so a
  // sweep is exactly RAM_DEPTH cycles; the counter is parked at 0 in READY
  // so the next sweep starts from address 0 without extra logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt    = ST_READY;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        w_clr_addr_nxt = '0;
        if (clr) w_state_nxt = ST_CLEAR;
      end
      default: begin
        w_state_nxt    = ST_CLEAR;
        w_clr_addr_nxt = '0;
      end
    endcase
  end

  always_comb begin
    ready    = (r_state == ST_READY);
    clr_we   = (r_state == ST_CLEAR);
    clr_addr = r_clr_addr;
  end

endmodule

// File: rtl/sramgen_sram_param_v2.sv
// Parameterised single-port SRAM model with lane write masks, 1- or 2-cycle
// read latency, optional write-through, and a self-timed zeroing sweep.
//   clk, rstb     : rising-edge clock, asynchronous active-low reset
//   vdd, vss      : power pins (only with USE_POWER_PINS)
//   en, we        : access request, 1 = write / 0 = read
//   wmask         : per-lane write enable, lane k = din[k*LW +: LW]
//   addr, din     : word address, write data
//   clr           : one-cycle request to zero the whole array
//   ready         : array accepts accesses
//   dout          : read (or write-through) data, held when not valid
//   dout_valid    : dout carries a fresh result this cycle
module sramgen_sram_param_v2
  import sramgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned WMASK_WIDTH   = 2,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_THROUGH = 0
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   clr,
  output logic                   ready,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW        = DATA_WIDTH / WMASK_WIDTH;

  if (!rl_legal(READ_LATENCY)) begin : g_bad_read_latency
    $error("sramgen_sram_param_v2: READ_LATENCY must be 1 or 2");
  end
  if (!wt_legal(WRITE_THROUGH)) begin : g_bad_write_through
    $error("sramgen_sram_param_v2: WRITE_THROUGH must be 0 or 1");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_wmask
    $error("sramgen_sram_param_v2: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  logic                  w_ready;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_res_valid;
  logic [DATA_WIDTH-1:0] w_res_data;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  sramgen_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rstb     (rstb),
    .clr      (clr),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A clr taking effect on this edge wins over a same-edge access.
  assign w_accept  = en && w_ready && !clr;
  assign w_rd_word = r_mem[addr];

  // The single read port serves both plain reads and the read half of a
  // masked read-modify-write; only one access is accepted per cycle.
  always_comb begin
    w_merged = w_rd_word;
    for (int k = 0; k < int'(WMASK_WIDTH); k++) begin
      if (wmask[k]) w_merged[k*LW +: LW] = din[k*LW +: LW];
    end
  end

  assign w_res_valid = w_accept && (!we || (WRITE_THROUGH != 0));
  assign w_res_data  = we ? w_merged : w_rd_word;

  // Array is intentionally not reset; zeroing only happens through the sweep.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_accept && we) begin
      r_mem[addr] <= w_merged;
    end
  end

  // Extra stage for READ_LATENCY=2; it is not flushed by clr, so results
  // already in flight still complete when a sweep starts behind them.
  if (READ_LATENCY == 2) begin : g_rl2
    logic                  r_p1_valid;
    logic [DATA_WIDTH-1:0] r_p1_data;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_p1_valid <= 1'b0;
        r_p1_data  <= '0;
      end else begin
        r_p1_valid <= w_res_valid;
        if (w_res_valid) r_p1_data <= w_res_data;
      end
    end

    assign w_out_valid = r_p1_valid;
    assign w_out_data  = r_p1_data;
  end else begin : g_rl1
    assign w_out_valid = w_res_valid;
    assign w_out_data  = w_res_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_out_valid;
      if (w_out_valid) r_dout <= w_out_data;
    end
  end

  assign ready      = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sramgen_sram_param_v2.sv
// Two instances share one stimulus stream: u_dut_a uses the defaults
// (READ_LATENCY=1, WRITE_THROUGH=0), u_dut_b uses READ_LATENCY=2,
// WRITE_THROUGH=1. A word-level model predicts each instance's results,
// queues them with the cycle they must appear, and a negedge monitor
// pops and compares.
module tb_sramgen_sram_param_v2;

  localparam int DW    = 4;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk   = 1'b0;
  logic          rstb  = 1'b0;
  logic          en    = 1'b0;
  logic          we    = 1'b0;
  logic          clr   = 1'b0;
  logic [1:0]    wmask = '0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] din   = '0;

  logic          ready_a, dv_a, ready_b, dv_b;
  logic [DW-1:0] dout_a, dout_b;

  always #5 clk = ~clk;

  sramgen_sram_param_v2 u_dut_a (
    .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .clr(clr), .ready(ready_a), .dout(dout_a), .dout_valid(dv_a)
  );

  sramgen_sram_param_v2 #(
    .READ_LATENCY(2), .WRITE_THROUGH(1)
  ) u_dut_b (
    .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .clr(clr), .ready(ready_b), .dout(dout_b), .dout_valid(dv_b)
  );

  typedef struct {
    int            when;
    logic [DW-1:0] data;
  } exp_t;

  int            n_cmp  = 0;
  int            n_bad  = 0;
  int            edge_n = 0;
  int            busy   = DEPTH;
  logic [DW-1:0] mdl [DEPTH];
  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // Word-level behaviour at one rising edge, using the inputs applied to it.
  task automatic model_edge();
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    logic [DW-1:0] bm;
    if (busy > 0) begin
      busy--;
    end else if (clr) begin
      busy = DEPTH;
      model_zero();
    end else if (en) begin
      old_w = mdl[addr];
      bm    = {{2{wmask[1]}}, {2{wmask[0]}}};
      new_w = (din & bm) | (old_w & ~bm);
      if (we) begin
        mdl[addr] = new_w;
        q_b.push_back('{edge_n + 1, new_w});
      end else begin
        q_a.push_back('{edge_n, old_w});
        q_b.push_back('{edge_n + 1, old_w});
      end
    end
  endtask

  task automatic cyc(input logic i_en, input logic i_we, input logic [1:0] i_m,
                     input logic [AW-1:0] i_a, input logic [DW-1:0] i_d, input logic i_clr);
    en = i_en; we = i_we; wmask = i_m; addr = i_a; din = i_d; clr = i_clr;
    @(posedge clk);
    edge_n++;
    if (rstb) model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b1, 1'b0, 2'b00, a, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
    cyc(1'b1, 1'b1, m, a, d, 1'b0);
  endtask

  task automatic reset_pulse();
    rstb = 1'b0;
    #1;
    check("rst_ready_a", ready_a, 1'b0);
    check("rst_ready_b", ready_b, 1'b0);
    check("rst_dv_a", dv_a, 1'b0);
    check("rst_dv_b", dv_b, 1'b0);
    check("rst_dout_a", dout_a, 4'h0);
    check("rst_dout_b", dout_b, 4'h0);
    busy = DEPTH;
    model_zero();
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    idle(3);
    rstb = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (rstb) begin
      check("ready_a", ready_a, busy == 0);
      check("ready_b", ready_b, busy == 0);

      exp_v = (q_a.size() > 0) && (q_a[0].when == edge_n);
      check("valid_a", dv_a, exp_v);
      if (exp_v) begin
        e = q_a.pop_front();
        check("dout_a", dout_a, e.data);
        last_a = e.data;
      end else begin
        check("hold_a", dout_a, last_a);
      end

      exp_v = (q_b.size() > 0) && (q_b[0].when == edge_n);
      check("valid_b", dv_b, exp_v);
      if (exp_v) begin
        e = q_b.pop_front();
        check("dout_b", dout_b, e.data);
        last_b = e.data;
      end else begin
        check("hold_b", dout_b, last_b);
      end
    end
  end

  initial begin
    model_zero();
    // Initial reset, then abort a sweep at address 30 and restart it.
    reset_pulse();
    idle(30);
    reset_pulse();
    idle(DEPTH);

    // Fresh array reads zero at both ends.
    rd(6'd0);
    rd(6'd63);

    // Masked write into a zero word, then read back.
    wr(6'd5, 4'hF, 2'b01);
    rd(6'd5);

    // Lane merge: 4'hA upper lane over 4'h5.
    wr(6'd7, 4'h5, 2'b11);
    wr(6'd7, 4'hA, 2'b10);
    rd(6'd7);

    // No-op write, back-to-back reads, read right after a write.
    wr(6'd7, 4'h0, 2'b00);
    rd(6'd1); rd(6'd2); rd(6'd3);
    wr(6'd9, 4'hC, 2'b11);
    rd(6'd9);
    rd(6'd7);
    idle(3);

    // Randomised traffic on a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), ($urandom_range(0, 199) == 0));
    end
    idle(DEPTH + 2);

    // Load memory, issue a read, then clr behind it with a same-edge write.
    for (int a = 0; a < DEPTH; a++) wr(6'(a), 4'($urandom_range(1, 15)), 2'b11);
    rd(6'd12);
    cyc(1'b1, 1'b1, 2'b11, 6'd4, 4'hE, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(1'b1, ($urandom_range(0, 1) == 1), 2'b11, 6'($urandom_range(0, 63)),
          4'hF, ($urandom_range(0, 7) == 0));
    end
    for (int a = 0; a < DEPTH; a++) rd(6'(a));
    idle(4);

    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
